// File: rtl/hdmi_timing_pkg.sv
// hdmi_timing_pkg: 640x480@60 raster defaults and sync polarities shared across the HDMI path
package hdmi_timing_pkg;
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FRONT = 16;
  localparam int VGA_H_SYNC = 96;
  localparam int VGA_H_BACK = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FRONT = 10;
  localparam int VGA_V_SYNC = 2;
  localparam int VGA_V_BACK = 33;
  localparam int VGA_CNT_W = 10;
  localparam int VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
  localparam int VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;
  localparam int VGA_H_SYNC_START = VGA_H_ACTIVE + VGA_H_FRONT;
  localparam int VGA_H_SYNC_END = VGA_H_SYNC_START + VGA_H_SYNC;
  localparam int VGA_V_SYNC_START = VGA_V_ACTIVE + VGA_V_FRONT;
  localparam int VGA_V_SYNC_END = VGA_V_SYNC_START + VGA_V_SYNC;
  localparam bit VGA_HSYNC_POL = 1'b0;
  localparam bit VGA_VSYNC_POL = 1'b0;
endpackage

// File: rtl/video_timing_gen_if.sv
// video_timing_gen_if: enable in, sync/de/coordinate/pulse outputs of the raster generator
interface video_timing_gen_if #(parameter int CNT_W = hdmi_timing_pkg::VGA_CNT_W);
  logic enable;
  logic hsync;
  logic vsync;
  logic de;
  logic [CNT_W-1:0] x;
  logic [CNT_W-1:0] y;
  logic line_start;
  logic frame_start;
  modport master (input enable, output hsync, vsync, de, x, y, line_start, frame_start);
  modport slave (output enable, input hsync, vsync, de, x, y, line_start, frame_start);
endinterface

// File: rtl/video_timing_axis.sv
// video_timing_axis: wrapping counter with active-region and sync-window decode
module video_timing_axis #(
  parameter int PERIOD = 800,
  parameter int ACTIVE = 640,
  parameter int SYNC_START = 656,
  parameter int SYNC_END = 752,
  parameter int W = 10
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         step,
  output logic [W-1:0] cnt,
  output logic         wrap,
  output logic         in_active,
  output logic         in_sync
);
  // count advances only on step and returns to zero after the last position
  always_ff @(posedge clock)
    cnt <= reset ? '0 : step ? (wrap ? '0 : cnt + W'(1)) : cnt;
  // wrap strobe is qualified by step so it can chain directly into the next axis
  always_comb begin
    wrap = step && (cnt == W'(PERIOD - 1));
    in_active = cnt < W'(ACTIVE);
    in_sync = (cnt >= W'(SYNC_START)) && (cnt < W'(SYNC_END));
  end
endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: registered hsync/vsync/de/coordinates/pulses for a parameterised raster
module video_timing_gen
  import hdmi_timing_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FRONT = VGA_H_FRONT,
  parameter int H_SYNC = VGA_H_SYNC,
  parameter int H_BACK = VGA_H_BACK,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FRONT = VGA_V_FRONT,
  parameter int V_SYNC = VGA_V_SYNC,
  parameter int V_BACK = VGA_V_BACK,
  parameter bit HSYNC_POL = VGA_HSYNC_POL,
  parameter bit VSYNC_POL = VGA_VSYNC_POL,
  parameter int CNT_W = VGA_CNT_W
) (
  input logic clock,
  input logic reset,
  video_timing_gen_if.master vt
);
  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic h_wrap, h_act, h_sync, v_wrap_unused, v_act, v_sync;
  video_timing_axis #(
    .PERIOD(H_TOTAL), .ACTIVE(H_ACTIVE), .SYNC_START(H_ACTIVE + H_FRONT),
    .SYNC_END(H_ACTIVE + H_FRONT + H_SYNC), .W(CNT_W)
  ) u_h (
    .clock(clock), .reset(reset), .step(vt.enable), .cnt(h_cnt),
    .wrap(h_wrap), .in_active(h_act), .in_sync(h_sync)
  );
  video_timing_axis #(
    .PERIOD(V_TOTAL), .ACTIVE(V_ACTIVE), .SYNC_START(V_ACTIVE + V_FRONT),
    .SYNC_END(V_ACTIVE + V_FRONT + V_SYNC), .W(CNT_W)
  ) u_v (
    .clock(clock), .reset(reset), .step(h_wrap), .cnt(v_cnt),
    .wrap(v_wrap_unused), .in_active(v_act), .in_sync(v_sync)
  );
  // outputs register the decode of the pre-edge counters so x/y match the syncs shown with them
  always_ff @(posedge clock)
    if (reset) begin
      vt.hsync <= ~HSYNC_POL;
      vt.vsync <= ~VSYNC_POL;
      vt.de <= 1'b0;
      vt.x <= '0;
      vt.y <= '0;
      vt.line_start <= 1'b0;
      vt.frame_start <= 1'b0;
    end else if (vt.enable) begin
      vt.hsync <= h_sync ? HSYNC_POL : ~HSYNC_POL;
      vt.vsync <= v_sync ? VSYNC_POL : ~VSYNC_POL;
      vt.de <= h_act && v_act;
      vt.x <= h_cnt;
      vt.y <= v_cnt;
      vt.line_start <= h_cnt == '0;
      vt.frame_start <= (h_cnt == '0) && (v_cnt == '0);
    end
endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: table vectors, per-cycle scoreboard and corner-case sequences on a short-frame raster
module tb_video_timing_gen;
  localparam int HA = 640, HF = 16, HS = 96, HB = 48;
  localparam int VA = 6, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic de, hs, vs, ls, fs;
  } out_t;

  typedef struct {
    logic r, e;
    int n;
    out_t exp_o;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  video_timing_gen_if #(.CNT_W(10)) vif ();
  video_timing_gen #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CNT_W(10)
  ) dut (.clock(clock), .reset(reset), .vt(vif));

  out_t q[$];
  out_t m_out;
  int mh, mv;
  int checks = 0, errors = 0;

  function automatic out_t now();
    return {vif.x, vif.y, vif.de, vif.hsync, vif.vsync, vif.line_start, vif.frame_start};
  endfunction

  task automatic chk(input string name, input int got, input int exp_v);
    checks++;
    if (got != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp_v);
    end
  endtask

  task automatic chk_out(input string name, input out_t exp_o);
    out_t got = now();
    checks++;
    if (got !== exp_o) begin
      errors++;
      $display("FAIL %s: got x=%0d y=%0d de=%b hs=%b vs=%b ls=%b fs=%b expected x=%0d y=%0d de=%b hs=%b vs=%b ls=%b fs=%b",
               name, got.x, got.y, got.de, got.hs, got.vs, got.ls, got.fs,
               exp_o.x, exp_o.y, exp_o.de, exp_o.hs, exp_o.vs, exp_o.ls, exp_o.fs);
    end
  endtask

  task automatic tick(input logic r, input logic e);
    reset = r;
    vif.enable = e;
    if (r) begin
      mh = 0;
      mv = 0;
      m_out = '{x: 10'd0, y: 10'd0, de: 1'b0, hs: 1'b1, vs: 1'b1, ls: 1'b0, fs: 1'b0};
    end else if (e) begin
      m_out.x = 10'(mh);
      m_out.y = 10'(mv);
      m_out.de = (mh < HA) && (mv < VA);
      m_out.hs = !((mh >= HA + HF) && (mh < HA + HF + HS));
      m_out.vs = !((mv >= VA + VF) && (mv < VA + VF + VS));
      m_out.ls = mh == 0;
      m_out.fs = (mh == 0) && (mv == 0);
      mh++;
      if (mh == HT) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end
    end
    q.push_back(m_out);
    @(posedge clock);
    #1;
    chk_out("scoreboard", q.pop_front());
  endtask

  // sel 0: position (tx,ty); 1: line_start; 2: frame_start
  task automatic run_until(input int sel, input int tx, input int ty, input int limit, input string name);
    int k = 0;
    while (!((sel == 0 && vif.x == 10'(tx) && vif.y == 10'(ty)) || (sel == 1 && vif.line_start) ||
             (sel == 2 && vif.frame_start)) && k < limit) begin
      tick(1'b0, 1'b1);
      k++;
    end
    checks++;
    if (k >= limit) begin
      errors++;
      $display("FAIL %s: target not reached after %0d cycles, expected within %0d", name, k, limit);
    end
  endtask

  vec_t tbl[10];
  int n, de_c, hs_c, vs_c, first_hs, fall_x, fall_y;
  logic prev_vs;

  initial begin
    vif.enable = 1'b1;
    tbl[0] = '{1'b1, 1'b1, 5,   '{10'd0,   10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}};
    tbl[1] = '{1'b0, 1'b1, 1,   '{10'd0,   10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1}};
    tbl[2] = '{1'b0, 1'b1, 1,   '{10'd1,   10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}};
    tbl[3] = '{1'b0, 1'b1, 639, '{10'd640, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}};
    tbl[4] = '{1'b0, 1'b1, 16,  '{10'd656, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}};
    tbl[5] = '{1'b0, 1'b1, 95,  '{10'd751, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}};
    tbl[6] = '{1'b0, 1'b1, 1,   '{10'd752, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}};
    tbl[7] = '{1'b0, 1'b1, 48,  '{10'd0,   10'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0}};
    tbl[8] = '{1'b0, 1'b0, 10,  '{10'd0,   10'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0}};
    tbl[9] = '{1'b0, 1'b1, 1,   '{10'd1,   10'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}};
    foreach (tbl[i]) begin
      repeat (tbl[i].n) tick(tbl[i].r, tbl[i].e);
      chk_out($sformatf("vector%0d", i), tbl[i].exp_o);
    end

    run_until(1, 0, 0, 2000, "line_wait");
    n = 0; de_c = 0; hs_c = 0; first_hs = -1;
    do begin
      if (vif.de) de_c++;
      if (!vif.hsync) begin
        hs_c++;
        if (first_hs < 0) first_hs = int'(vif.x);
      end
      tick(1'b0, 1'b1);
      n++;
    end while (!vif.line_start && n < 2000);
    chk("line_period", n, 800);
    chk("line_de_count", de_c, 640);
    chk("hsync_low_count", hs_c, 96);
    chk("hsync_first_x", first_hs, 656);

    run_until(2, 0, 0, 2 * HT * VT, "frame_wait");
    n = 0; de_c = 0; vs_c = 0; fall_x = -1; fall_y = -1;
    do begin
      if (vif.de) de_c++;
      if (!vif.vsync) vs_c++;
      prev_vs = vif.vsync;
      tick(1'b0, 1'b1);
      n++;
      if (prev_vs && !vif.vsync && fall_x < 0) begin
        fall_x = int'(vif.x);
        fall_y = int'(vif.y);
      end
    end while (!vif.frame_start && n < 2 * HT * VT);
    chk("frame_period", n, 10400);
    chk("frame_de_count", de_c, 3840);
    chk("vsync_low_count", vs_c, 1600);
    chk("vsync_fall_x", fall_x, 0);
    chk("vsync_fall_y", fall_y, 8);

    run_until(0, 799, 12, 2 * HT * VT, "wrap_wait");
    tick(1'b0, 1'b1);
    chk_out("wrap", '{10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1});

    run_until(0, 0, 5, 2 * HT * VT, "freeze_line_wait");
    n = 0;
    while (vif.x != 10'd300 && n < 2000) begin
      tick(1'b0, 1'b1);
      n++;
    end
    repeat (37) begin
      tick(1'b0, 1'b0);
      n++;
    end
    chk_out("frozen", '{10'd300, 10'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
    tick(1'b0, 1'b1);
    n++;
    chk_out("resume", '{10'd301, 10'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
    while (!vif.line_start && n < 3000) begin
      tick(1'b0, 1'b1);
      n++;
    end
    chk("stalled_line_period", n, 837);

    run_until(0, 700, 9, 2 * HT * VT, "reset_pos_wait");
    chk_out("pre_reset", '{10'd700, 10'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    repeat (3) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    chk_out("mid_reset", '{10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
    repeat (2) tick(1'b1, 1'b1);
    tick(1'b0, 1'b1);
    chk_out("restart", '{10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1});
    tick(1'b0, 1'b1);
    chk_out("restart_next", '{10'd1, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
